// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard unit for the ID/EX boundary.
// Tracks in-flight writebacks in a DEPTH-deep shift scoreboard and drives per-operand bypass selects.
module fwd_hazard_unit #(
    parameter int REG_W    = 4,
    parameter int DEPTH    = 2,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16,
    parameter int SEL_W    = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue_valid,
    input  logic [REG_W-1:0]           issue_dest,
    input  logic                       issue_wb_en,
    input  logic                       issue_mem_read,
    input  logic [NUM_SRC*REG_W-1:0]   src_addr,
    input  logic [NUM_SRC-1:0]         src_valid,
    input  logic                       forward_en,
    input  logic                       freeze,
    input  logic                       flush,
    output logic [NUM_SRC*SEL_W-1:0]   sel_src,
    output logic                       hazard_stall,
    output logic [CNT_W-1:0]           stall_cycles
);

    logic [DEPTH-1:0]              ent_valid;
    logic [DEPTH-1:0]              ent_load;
    logic [DEPTH-1:0][REG_W-1:0]   ent_dest;

    logic [NUM_SRC-1:0]            src_hit;
    logic [NUM_SRC-1:0]            src_load_use;
    logic [NUM_SRC-1:0][SEL_W-1:0] src_fwd_sel;
    logic                          stall_any;
    logic                          insert;

    // Scan oldest to youngest so the youngest matching entry ends up winning.
    always_comb begin
        src_hit      = '0;
        src_load_use = '0;
        src_fwd_sel  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (src_valid[i] && ent_valid[k] &&
                    (ent_dest[k] == src_addr[i*REG_W +: REG_W])) begin
                    src_hit[i]      = 1'b1;
                    src_load_use[i] = ent_load[k] && (k < LOAD_LAT);
                    src_fwd_sel[i]  = SEL_W'(k + 1);
                end
            end
        end
    end

    always_comb begin
        sel_src   = '0;
        stall_any = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (forward_en) begin
                if (src_load_use[i]) begin
                    stall_any = 1'b1;
                end else begin
                    sel_src[i*SEL_W +: SEL_W] = src_fwd_sel[i];
                end
            end else if (src_hit[i]) begin
                stall_any = 1'b1;
            end
        end
    end

    assign hazard_stall = issue_valid & stall_any;
    assign insert       = issue_valid & issue_wb_en & ~flush & ~hazard_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_valid    <= '0;
            ent_load     <= '0;
            ent_dest     <= '0;
            stall_cycles <= '0;
        end else if (!freeze) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                ent_valid[k] <= ent_valid[k-1];
                ent_load[k]  <= ent_load[k-1];
                ent_dest[k]  <= ent_dest[k-1];
            end
            ent_valid[0] <= insert;
            ent_load[0]  <= insert & issue_mem_read;
            ent_dest[0]  <= insert ? issue_dest : '0;
            if (hazard_stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
        end
    end

endmodule
